// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus a WIDTH-step shift-add unsigned multiply,
// with valid/ready handshakes on both operand and result sides.
module seq_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned W2  = 2 * WIDTH;
  localparam int unsigned WP1 = WIDTH + 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t           state, state_d;
  logic [W2-1:0]    mcand, mcand_d;
  logic [W2-1:0]    acc, acc_d;
  logic [WIDTH-1:0] mplier, mplier_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             out_valid_d;
  logic [WIDTH-1:0] result_d, result_hi_d;
  logic             zero_d, carry_out_d, overflow_d;

  logic [WIDTH:0]   add_full, sub_full;
  logic             add_ovf, sub_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry, alu_ovf;
  logic             accept;
  logic [W2-1:0]    acc_step;

  assign in_ready = (state == S_IDLE) | ((state == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  // Single-cycle datapath; only consumed on an accept so idle X on a/b/op never reaches a register.
  always_comb begin
    add_full  = {1'b0, a} + {1'b0, b};
    sub_full  = {1'b0, a} + {1'b0, ~b} + WP1'(1);
    add_ovf   = (a[WIDTH-1] == b[WIDTH-1]) & (add_full[WIDTH-1] != a[WIDTH-1]);
    sub_ovf   = (a[WIDTH-1] != b[WIDTH-1]) & (sub_full[WIDTH-1] != a[WIDTH-1]);
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_NOR: alu_res = ~(a | b);
      OP_ADD: begin
        alu_res   = add_full[WIDTH-1:0];
        alu_carry = add_full[WIDTH];
        alu_ovf   = add_ovf;
      end
      OP_SUB: begin
        alu_res   = sub_full[WIDTH-1:0];
        alu_carry = sub_full[WIDTH];
        alu_ovf   = sub_ovf;
      end
      OP_SLT: begin
        alu_res   = WIDTH'(sub_full[WIDTH-1] ^ sub_ovf);
        alu_carry = sub_full[WIDTH];
      end
      default: alu_res = '0;
    endcase
  end

  assign acc_step = acc + (mplier[0] ? mcand : W2'(0));

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state;
    mcand_d     = mcand;
    acc_d       = acc;
    mplier_d    = mplier;
    cnt_d       = cnt;
    out_valid_d = out_valid;
    result_d    = result;
    result_hi_d = result_hi;
    zero_d      = zero;
    carry_out_d = carry_out;
    overflow_d  = overflow;

    case (state)
      S_IDLE, S_DONE: begin
        if ((state == S_DONE) && out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
        if (accept) begin
          if (op == OP_MUL) begin
            mcand_d     = W2'(a);
            mplier_d    = b;
            acc_d       = '0;
            cnt_d       = CNT_W'(WIDTH);
            state_d     = S_MUL;
            out_valid_d = 1'b0;
          end else begin
            result_d    = alu_res;
            result_hi_d = '0;
            zero_d      = (alu_res == '0);
            carry_out_d = alu_carry;
            overflow_d  = alu_ovf;
            state_d     = S_DONE;
            out_valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (cnt != '0) begin
          acc_d    = acc_step;
          mcand_d  = mcand << 1;
          mplier_d = mplier >> 1;
          cnt_d    = cnt - CNT_W'(1);
        end else begin
          // Step counter exhausted: publish the accumulated product.
          result_d    = acc[WIDTH-1:0];
          result_hi_d = acc[W2-1:WIDTH];
          zero_d      = (acc[WIDTH-1:0] == '0);
          carry_out_d = 1'b0;
          overflow_d  = 1'b0;
          state_d     = S_DONE;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mcand     <= '0;
      acc       <= '0;
      mplier    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_d;
      mcand     <= mcand_d;
      acc       <= acc_d;
      mplier    <= mplier_d;
      cnt       <= cnt_d;
      out_valid <= out_valid_d;
      result    <= result_d;
      result_hi <= result_hi_d;
      zero      <= zero_d;
      carry_out <= carry_out_d;
      overflow  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=32.
module tb_seq_alu;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             carry_out;
  logic             overflow;

  int n_checks;
  int n_fail;

  seq_alu #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .result_hi(result_hi),
    .zero(zero), .carry_out(carry_out), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operation at a negedge; returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 'x; a = 'x; b = 'x;
  endtask

  task automatic release_out;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  // Cycles from the accept edge until out_valid; counts cycles where in_ready was not low.
  task automatic wait_valid(output int lat, output int busy_viol);
    lat = 0; busy_viol = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready !== 1'b0) busy_viol++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    n_checks++; if (result_hi !== 32'h0) begin n_fail++; $display("FAIL reset_result_hi: got %h want 0", result_hi); end
    n_checks++; if ({zero, carry_out, overflow} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {zero, carry_out, overflow}); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    issue(3'b010, 32'h7FFF_FFFF, 32'h1);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_latency: out_valid got %b want 1", out_valid); end
    n_checks++; if (result !== 32'h8000_0000) begin n_fail++; $display("FAIL add_result: got %h want 80000000", result); end
    n_checks++; if ({zero, carry_out, overflow} !== 3'b001) begin n_fail++; $display("FAIL add_flags zco: got %b want 001", {zero, carry_out, overflow}); end
    n_checks++; if (result_hi !== 32'h0) begin n_fail++; $display("FAIL add_result_hi: got %h want 0", result_hi); end
    release_out;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_release_valid: got %b want 0", out_valid); end
    n_checks++; if (result !== 32'h8000_0000) begin n_fail++; $display("FAIL add_release_hold: got %h want 80000000", result); end
  endtask

  task automatic test_sub_slt_nor;
    issue(3'b110, 32'd5, 32'd5);
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL sub_eq_result: got %h want 0", result); end
    n_checks++; if ({zero, carry_out, overflow} !== 3'b110) begin n_fail++; $display("FAIL sub_eq_flags zco: got %b want 110", {zero, carry_out, overflow}); end
    release_out;
    issue(3'b110, 32'h8000_0000, 32'h1);
    n_checks++; if (result !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sub_ovf_result: got %h want 7fffffff", result); end
    n_checks++; if ({zero, carry_out, overflow} !== 3'b011) begin n_fail++; $display("FAIL sub_ovf_flags zco: got %b want 011", {zero, carry_out, overflow}); end
    release_out;
    issue(3'b111, 32'hFFFF_FFFF, 32'h1);
    n_checks++; if (result !== 32'h1) begin n_fail++; $display("FAIL slt_neg_result: got %h want 1", result); end
    n_checks++; if ({zero, carry_out, overflow} !== 3'b010) begin n_fail++; $display("FAIL slt_neg_flags zco: got %b want 010", {zero, carry_out, overflow}); end
    release_out;
    issue(3'b111, 32'h1, 32'hFFFF_FFFF);
    n_checks++; if (result !== 32'h0 || zero !== 1'b1) begin n_fail++; $display("FAIL slt_pos_result: got %h z=%b want 0 z=1", result, zero); end
    release_out;
    issue(3'b100, 32'h0, 32'h0);
    n_checks++; if (result !== 32'hFFFF_FFFF || zero !== 1'b0) begin n_fail++; $display("FAIL nor_result: got %h z=%b want ffffffff z=0", result, zero); end
    release_out;
    issue(3'b000, 32'hF0F0_1234, 32'h0FF0_FF00);
    n_checks++; if (result !== 32'h00F0_1200) begin n_fail++; $display("FAIL and_result: got %h want 00f01200", result); end
    release_out;
  endtask

  task automatic test_mul;
    int lat, viol;
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_valid(lat, viol);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL mul_latency: got %0d want 33", lat); end
    n_checks++; if (viol != 0) begin n_fail++; $display("FAIL mul_busy_in_ready: %0d cycles high, want 0", viol); end
    n_checks++; if (result_hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mul_max_hi: got %h want fffffffe", result_hi); end
    n_checks++; if (result !== 32'h1) begin n_fail++; $display("FAIL mul_max_lo: got %h want 1", result); end
    n_checks++; if ({zero, carry_out, overflow} !== 3'b000) begin n_fail++; $display("FAIL mul_max_flags zco: got %b want 000", {zero, carry_out, overflow}); end
    release_out;
    issue(3'b011, 32'h0, 32'h1234);
    wait_valid(lat, viol);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL mul_zero_latency: got %0d want 33", lat); end
    n_checks++; if (result !== 32'h0 || result_hi !== 32'h0 || zero !== 1'b1) begin n_fail++; $display("FAIL mul_zero: got hi=%h lo=%h z=%b want 0/0 z=1", result_hi, result, zero); end
    release_out;
    issue(3'b011, 32'h0001_0000, 32'h0001_0000);
    wait_valid(lat, viol);
    n_checks++; if (result_hi !== 32'h1 || result !== 32'h0 || zero !== 1'b1) begin n_fail++; $display("FAIL mul_hi_only: got hi=%h lo=%h z=%b want 1/0 z=1", result_hi, result, zero); end
    release_out;
  endtask

  task automatic test_backpressure;
    int bad;
    issue(3'b010, 32'd3, 32'd4);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (result !== 32'd7 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL backpressure_hold: %0d bad cycles, want 0 (last res=%h v=%b rdy=%b)", bad, result, out_valid, in_ready); end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; op = 3'b001; a = 32'hF0; b = 32'h0F;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL backpressure_ready_passthru: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0; op = 'x; a = 'x; b = 'x;
    n_checks++; if (out_valid !== 1'b1 || result !== 32'hFF) begin n_fail++; $display("FAIL back_to_back_or: got v=%b res=%h want v=1 res=ff", out_valid, result); end
    release_out;
  endtask

  task automatic test_reset_mid_mul;
    int lat, viol;
    issue(3'b011, 32'h1234_5678, 32'h9);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || result !== 32'h0 || result_hi !== 32'h0) begin n_fail++; $display("FAIL abort_outputs: got v=%b hi=%h lo=%h want 0", out_valid, result_hi, result); end
    n_checks++; if ({zero, carry_out, overflow} !== 3'b000) begin n_fail++; $display("FAIL abort_flags: got %b want 000", {zero, carry_out, overflow}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got rdy=%b v=%b want 1/0", in_ready, out_valid); end
    issue(3'b011, 32'd6, 32'd7);
    wait_valid(lat, viol);
    n_checks++; if (lat != 33 || result !== 32'd42 || result_hi !== 32'h0) begin n_fail++; $display("FAIL post_reset_mul: got lat=%0d hi=%h lo=%h want 33/0/2a", lat, result_hi, result); end
    release_out;
  endtask

  task automatic test_reserved_and_back_to_back;
    int lat, viol;
    issue(3'b101, 32'hAAAA_5555, 32'hAAAA_5555);
    n_checks++; if (out_valid !== 1'b1 || result !== 32'h0 || result_hi !== 32'h0) begin n_fail++; $display("FAIL reserved_result: got v=%b hi=%h lo=%h want 1/0/0", out_valid, result_hi, result); end
    n_checks++; if ({zero, carry_out, overflow} !== 3'b100) begin n_fail++; $display("FAIL reserved_flags zco: got %b want 100", {zero, carry_out, overflow}); end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; op = 3'b011; a = 32'd100; b = 32'd1000;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0; op = 'x; a = 'x; b = 'x;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_mul_entry: got v=%b rdy=%b want 0/0", out_valid, in_ready); end
    wait_valid(lat, viol);
    n_checks++; if (lat != 33 || result !== 32'd100000 || viol != 0) begin n_fail++; $display("FAIL b2b_mul_result: got lat=%0d lo=%h viol=%0d want 33/186a0/0", lat, result, viol); end
    release_out;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    in_valid = 1'b0; out_ready = 1'b0; op = 'x; a = 'x; b = 'x;
    test_reset;
    test_add;
    test_sub_slt_nor;
    test_mul;
    test_backpressure;
    test_reset_mid_mul;
    test_reserved_and_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
